id_ex: RTL and testbench

//  ID->EX pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/id_ex.sv | 107 ++++++++++
 tb/tb_id_ex.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/id_ex.sv
// rtl/id_ex.sv - ID->EX pipeline register with valid/ready handshake and 2-entry skid buffer
//
// Purpose:
//   Holds one decoded instruction (main slot) for the EX stage, plus one
//   overflow entry (skid slot) so that id_ready_o can be a pure flop output
//   with no combinational path from ex_ready_i. Order is strictly FIFO:
//   main drains first, then skid moves up into main. flush_i discards both
//   slots and any entry offered in the same cycle. When main is empty the
//   outputs present a NOP bubble so stale payload never reaches EX.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   flush_i             drop all held and incoming entries
//   id_valid_i          upstream offers an entry
//   id_ready_o          entry can be accepted (skid slot free), from a flop
//   inst_i .. reg_wen_i upstream payload
//   ex_valid_o          main slot holds a valid entry
//   ex_ready_i          downstream consumes the main slot this cycle
//   inst_o .. reg_wen_o main slot payload, or bubble values when invalid

module id_ex #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,

  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op_num1_i,
  input  logic [XLEN-1:0] op_num2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,

  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op_num1_o,
  output logic [XLEN-1:0] op_num2_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  // Payload layout: {inst, addr, op1, op2, rd, wen}
  localparam int PW = 4 * XLEN + 6;

  // Bubble: NOP instruction word, every other field (including wen) zero
  localparam logic [PW-1:0] BUBBLE = {NOP_INST, {(PW - XLEN){1'b0}}};

  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic          r_main_v;
  logic          r_skid_v;

  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] w_out_payload;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_main_free;

  assign w_in_payload = {inst_i, inst_addr_i, op_num1_i, op_num2_i, rd_addr_i, reg_wen_i};

  // Ready depends only on the skid flop, so in_fire never sees ex_ready_i
  assign w_in_fire   = id_valid_i & ~r_skid_v;
  assign w_out_fire  = r_main_v & ex_ready_i;
  assign w_main_free = ~r_main_v | w_out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (flush_i) begin
      // Flush beats every other event, including a same-cycle accept
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        // Skid full implies ready was low, so no new entry competes here
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_in_fire) begin
        r_main   <= w_in_payload;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (w_in_fire) begin
      // Main is stalled: park the new entry behind it
      r_skid   <= w_in_payload;
      r_skid_v <= 1'b1;
    end
  end

  assign w_out_payload = r_main_v ? r_main : BUBBLE;

  assign id_ready_o  = ~r_skid_v;
  assign ex_valid_o  = r_main_v;
  assign {inst_o, inst_addr_o, op_num1_o, op_num2_o, rd_addr_o, reg_wen_o} = w_out_payload;

endmodule

// File: tb/tb_id_ex.sv
// tb/tb_id_ex.sv - scoreboard testbench for id_ex
module tb_id_ex;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
  } pl_t;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic        id_ready_o;
  logic [31:0] inst_i = '0, inst_addr_i = '0, op_num1_i = '0, op_num2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        reg_wen_i = 1'b0;
  logic        ex_valid_o;
  logic        ex_ready_i = 1'b0;
  logic [31:0] inst_o, inst_addr_o, op_num1_o, op_num2_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int checks = 0;
  int failures = 0;

  // Entries accepted and not yet consumed, oldest first (at most two)
  pl_t exp_q[$];

  id_ex dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op_num1_i(op_num1_i),
    .op_num2_i(op_num2_i), .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op_num1_o(op_num1_o),
    .op_num2_o(op_num2_o), .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pl_t out_pl();
    return '{inst: inst_o, addr: inst_addr_o, op1: op_num1_o, op2: op_num2_o,
             rd: rd_addr_o, wen: reg_wen_o};
  endfunction

  function automatic pl_t rand_pl();
    return '{inst: $urandom, addr: $urandom, op1: $urandom, op2: $urandom,
             rd: 5'($urandom), wen: 1'($urandom)};
  endfunction

  // Monitor: outputs must show the oldest held entry, or a bubble when none
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", 134'(id_ready_o), 134'(exp_q.size() < 2));
      chk("valid", 134'(ex_valid_o), 134'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("payload", out_pl(), exp_q[0]);
      end else begin
        chk("bubble", out_pl(), {NOP, 102'd0});
      end
      if (!ex_valid_o) chk("wen_when_invalid", 134'(reg_wen_o), 134'd0);
    end
  end

  // One cycle of stimulus; the model then applies the upcoming edge
  task automatic step(input logic v, input logic r, input logic f, input pl_t p);
    bit in_f, out_f;
    @(posedge clk); #1;
    id_valid_i = v; ex_ready_i = r; flush_i = f;
    {inst_i, inst_addr_i, op_num1_i, op_num2_i, rd_addr_i, reg_wen_i} = p;
    @(negedge clk); #1;
    in_f  = v && (exp_q.size() < 2);
    out_f = (exp_q.size() > 0) && r;
    if (f) begin
      exp_q.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back(p);
    end
  endtask

  task automatic idle_after_edge();
    @(posedge clk); #1;
    id_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  pl_t pa, pb, pc;

  initial begin
    // Reset values while held in reset
    #1;
    chk("rst_valid", 134'(ex_valid_o), 134'd0);
    chk("rst_inst", 134'(inst_o), 134'(NOP));
    chk("rst_ready", 134'(id_ready_o), 134'd1);
    chk("rst_wen", 134'(reg_wen_o), 134'd0);
    @(negedge clk); rst_n = 1'b1;

    // Stream: back-to-back pushes with ex ready
    pa = '{inst: 32'h00500093, addr: 32'd0, op1: 32'd0, op2: 32'd5, rd: 5'd1, wen: 1'b1};
    pb = '{inst: 32'h00a00113, addr: 32'd4, op1: 32'd0, op2: 32'd10, rd: 5'd2, wen: 1'b1};
    step(1'b1, 1'b1, 1'b0, pa);
    step(1'b1, 1'b1, 1'b0, pb);
    chk("stream_inst", 134'(inst_o), 134'(32'h00500093));
    chk("stream_op2", 134'(op_num2_o), 134'd5);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("stream_addr2", 134'(inst_addr_o), 134'd4);
    step(1'b0, 1'b1, 1'b0, '0);

    // Back-pressure: A then B fill both slots, then drain in order
    pa = rand_pl(); pb = rand_pl();
    step(1'b1, 1'b0, 1'b0, pa);
    step(1'b1, 1'b0, 1'b0, pb);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("bp_full_ready", 134'(id_ready_o), 134'd0);
    chk("bp_main_is_a", out_pl(), pa);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("bp_second_is_b", out_pl(), pb);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("bp_ready_back", 134'(id_ready_o), 134'd1);

    // Flush with both slots full
    step(1'b1, 1'b0, 1'b0, rand_pl());
    step(1'b1, 1'b0, 1'b0, rand_pl());
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("flush_valid", 134'(ex_valid_o), 134'd0);
    chk("flush_inst", 134'(inst_o), 134'(NOP));
    step(1'b0, 1'b1, 1'b0, '0);

    // Flush together with a push: the push is dropped
    pc = rand_pl();
    step(1'b1, 1'b1, 1'b1, pc);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("flush_push_valid", 134'(ex_valid_o), 134'd0);

    // Asynchronous reset mid-cycle with both slots full
    step(1'b1, 1'b0, 1'b0, rand_pl());
    step(1'b1, 1'b0, 1'b0, rand_pl());
    idle_after_edge();
    chk("pre_rst_full", 134'(id_ready_o), 134'd0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", 134'(ex_valid_o), 134'd0);
    chk("arst_inst", 134'(inst_o), 134'(NOP));
    chk("arst_wen", 134'(reg_wen_o), 134'd0);
    chk("arst_ready", 134'(id_ready_o), 134'd1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Random traffic with sparse flushes
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) < 3), rand_pl());
    end

    // Drain whatever remains
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("drained", 134'(ex_valid_o), 134'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
